// File: rtl/hsclk_div_m_if.sv
// Signal bundle between the CPLD map/clock-switch logic and the HS clock divider.
// en is a level request, not a handshake: 0 asks for a low park at the next period
// boundary, 1 releases it; parked reports that the output is being held low.
interface hsclk_div_m_if;
    logic [1:0] div_sel;
    logic       en;
    logic       clkout;
    logic       rise_next;
    logic       parked;
    logic [1:0] cur_sel;
    logic       sel_chg;
    logic [1:0] state_dbg;

    modport master (
        output div_sel,
        output en,
        input  clkout,
        input  rise_next,
        input  parked,
        input  cur_sel,
        input  sel_chg,
        input  state_dbg
    );

    modport slave (
        input  div_sel,
        input  en,
        output clkout,
        output rise_next,
        output parked,
        output cur_sel,
        output sel_chg,
        output state_dbg
    );
endinterface

// File: rtl/hsclk_div_m.sv
// Programmable /2../8 divider for the CPU high-speed clock, 50 % duty, with
// boundary-aligned ratio changes and a low park for the HS/LS clock switch.
module hsclk_div_m #(
    parameter int SYNC_STAGES = 2
) (
    input  logic           hsclk_in,
    input  logic           rst,
    hsclk_div_m_if.slave   bus
);

    // Encoding chosen so clkout and parked are direct flop outputs (bit 0 / bit 1).
    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_HIGH = 2'b01,
        ST_PARK = 2'b10
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] cnt;
    logic [1:0] cnt_n;
    logic [1:0] cur_sel;
    logic [1:0] cur_sel_n;
    logic       sel_chg;
    logic       sel_chg_n;
    logic [1:0] sync_q [SYNC_STAGES];
    logic [1:0] sel_s;
    logic       phase_end;

    // div_sel comes from the PHI1 domain; only the last stage is ever used.
    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 2'b00;
            end
        end else begin
            sync_q[0] <= bus.div_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sel_s     = sync_q[SYNC_STAGES-1];
    assign phase_end = (cnt == cur_sel);

    always_ff @(posedge hsclk_in or posedge rst) begin
        if (rst) begin
            state   <= ST_LOW;
            cnt     <= 2'b00;
            cur_sel <= 2'b00;
            sel_chg <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cur_sel <= cur_sel_n;
            sel_chg <= sel_chg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cur_sel_n = cur_sel;
        sel_chg_n = 1'b0;
        unique case (state)
            ST_HIGH: begin
                // en is deliberately ignored here so a high phase is never cut short.
                if (phase_end) begin
                    state_n = ST_LOW;
                    cnt_n   = 2'b00;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    cur_sel_n = sel_s;
                    sel_chg_n = (sel_s != cur_sel);
                    if (bus.en) begin
                        state_n = ST_HIGH;
                        cnt_n   = 2'b00;
                    end else begin
                        state_n = ST_PARK;
                    end
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            ST_PARK: begin
                // Track the requested ratio so the first high phase after wake uses it.
                cur_sel_n = sel_s;
                sel_chg_n = (sel_s != cur_sel);
                if (bus.en) begin
                    state_n = ST_HIGH;
                    cnt_n   = 2'b00;
                end
            end
            default: begin
                state_n = ST_LOW;
                cnt_n   = 2'b00;
            end
        endcase
    end

    assign bus.clkout    = state[0];
    assign bus.parked    = state[1];
    assign bus.rise_next = !state[0] && bus.en && (state[1] || phase_end);
    assign bus.cur_sel   = cur_sel;
    assign bus.sel_chg   = sel_chg;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_hsclk_div_m.sv
// Directed vector table plus corner sequences and a randomised glitch sweep for hsclk_div_m.
module tb_hsclk_div_m;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hsclk_div_m_if bus();

    hsclk_div_m #(.SYNC_STAGES(2)) dut (
        .hsclk_in (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic       clk;
        logic       rn;
        logic       pk;
        logic [1:0] cur;
        logic       chg;
    } vec_t;

    vec_t       vq[$];
    logic [5:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    logic       s_clk, s_rn, s_pk, s_chg;
    logic [1:0] s_cur;

    logic mon_on = 1'b0;
    logic m_prev_ok, p_clk, p_rn, p_en;
    logic hi_known, lo_known;
    int   hi_cnt, lo_cnt, hi_h, lo_h;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic [1:0] s, input logic c, input logic rn,
                       input logic pk, input logic [1:0] cur, input logic chg);
        vq.push_back('{en: e, sel: s, clk: c, rn: rn, pk: pk, cur: cur, chg: chg});
    endtask

    task automatic mon_reset();
        m_prev_ok = 1'b0;
        hi_known  = 1'b0;
        lo_known  = 1'b0;
        hi_cnt    = 0;
        lo_cnt    = 0;
    endtask

    // Phase-length, rise_next and en checks on every sampled cycle.
    task automatic sample_and_monitor();
        logic rise, fall;
        s_clk = bus.clkout;
        s_rn  = bus.rise_next;
        s_pk  = bus.parked;
        s_cur = bus.cur_sel;
        s_chg = bus.sel_chg;
        if (mon_on) begin
            if (m_prev_ok) begin
                rise = !p_clk && s_clk;
                fall = p_clk && !s_clk;
                check("rise_next_vs_rise", int'(p_rn), int'(rise));
                if (rise) begin
                    check("rise_with_en", int'(p_en), 1);
                    if (lo_known) check("low_len", lo_cnt, lo_h);
                    hi_known = 1'b1;
                    hi_cnt   = 1;
                    hi_h     = int'(s_cur) + 1;
                end else if (fall) begin
                    if (hi_known) check("high_len", hi_cnt, hi_h);
                    lo_known = 1'b1;
                    lo_cnt   = 1;
                    lo_h     = int'(s_cur) + 1;
                end else if (s_clk) begin
                    hi_cnt++;
                end else if (!s_pk) begin
                    lo_cnt++;
                end
            end
            m_prev_ok = 1'b1;
        end
        p_clk = s_clk;
        p_rn  = s_rn;
        p_en  = bus.en;
    endtask

    // Entered and left at posedge+1: drive, sample mid-cycle, advance one edge.
    task automatic cycle(input logic e, input logic [1:0] s);
        bus.en      = e;
        bus.div_sel = s;
        #1;
        sample_and_monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] s);
        mon_on      = 1'b0;
        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.div_sel = s;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_reset();
        mon_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg_n, chg_at, guard, run;
        logic en_v;
        logic [1:0] sel_v;
        logic [5:0] got, exp;

        bus.en      = 1'b1;
        bus.div_sel = 2'b00;
        mon_reset();

        // en, sel | clk, rise_next, parked, cur_sel, sel_chg
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 2, 0, 0, 1, 1, 0);
        add(0, 2, 0, 0, 1, 1, 0);
        add(0, 2, 0, 0, 1, 1, 0);
        add(0, 2, 0, 0, 1, 2, 1);
        add(1, 2, 0, 1, 1, 2, 0);
        add(1, 2, 1, 0, 0, 2, 0);
        add(1, 2, 1, 0, 0, 2, 0);
        add(1, 2, 1, 0, 0, 2, 0);
        add(1, 2, 0, 0, 0, 2, 0);
        add(0, 2, 0, 0, 0, 2, 0);
        add(1, 2, 0, 1, 0, 2, 0);
        add(1, 2, 1, 0, 0, 2, 0);

        // Reset state, default /2, /4 run, park, change while parked, wake at /6.
        do_reset(2'b00);
        foreach (vq[i]) begin
            exp_q.push_back({vq[i].clk, vq[i].rn, vq[i].pk, vq[i].cur, vq[i].chg});
            cycle(vq[i].en, vq[i].sel);
            got = {s_clk, s_rn, s_pk, s_cur, s_chg};
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), int'(got), int'(exp));
        end

        // Ratio change 00 -> 11 driven during a high phase.
        do_reset(2'b00);
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        chg_n  = 0;
        chg_at = -1;
        for (int i = 3; i < 27; i++) begin
            cycle(1, 3);
            if (i == 3) check("mid_high_drive", int'(s_clk), 1);
            if (s_chg) begin
                chg_n++;
                if (chg_at < 0) chg_at = i;
            end
        end
        check("chg_count_00_11", chg_n, 1);
        check("chg_cycle_00_11", chg_at, 7);
        check("cur_sel_after_chg", int'(s_cur), 3);

        // Asynchronous reset two cycles into a /8 high phase.
        guard = 0;
        while (!(s_clk && hi_cnt == 1 && s_cur == 2'd3) && guard < 40) begin
            cycle(1, 3);
            guard++;
        end
        check("find_high_11", int'(guard < 40), 1);
        cycle(1, 3);
        #2;
        check("pre_rst_high", int'(bus.clkout), 1);
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        check("rst_clkout", int'(bus.clkout), 0);
        check("rst_cur_sel", int'(bus.cur_sel), 0);
        check("rst_parked", int'(bus.parked), 0);
        check("rst_sel_chg", int'(bus.sel_chg), 0);
        check("rst_rise_next", int'(bus.rise_next), 1);
        bus.div_sel = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_reset();
        mon_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0);
            check("div2_after_rst", int'(s_clk), i % 2);
        end

        // Random ratio steps with en toggling; the monitor checks every phase.
        en_v  = 1'b1;
        sel_v = 2'b00;
        run   = 0;
        for (int i = 0; i < 700; i++) begin
            if (run == 0) begin
                en_v = ($urandom_range(0, 9) < 7);
                run  = int'($urandom_range(1, 12));
            end
            run--;
            if ($urandom_range(0, 19) == 0) sel_v = 2'($urandom_range(0, 3));
            cycle(en_v, sel_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
